mem_io_unit: RTL
================

Name: mem_io_unit

Overview:
Load/store stage directly downstream of the instruction decoder. It consumes mem_read/mem_write/io_read/io_write/is_signed plus the ALU-computed address and store data. Accesses to 0xFFFFxxxx go to memory-mapped I/O; all other addresses go to a synchronous data RAM with 1-cycle read latency. It aligns, masks and extends the load data, and stalls the core for the RAM read-latency cycle.

Parameters:
DMEM_AW, 14, word-address width of the data RAM port.
SYNC_STAGES, 2, synchroniser depth on switch/button inputs (min 2).

Ports:
clk  in  1  core clock
rst_n  in  1  asynchronous active-low reset
mem_read  in  1  RAM load request (decoder)
mem_write  in  1  RAM store request (decoder)
io_read  in  1  MMIO load request (decoder)
io_write  in  1  MMIO store request (decoder)
is_signed  in  1  sign-extend load result
funct3  in  3  access width: [1:0]=0 byte, 1 half, 2 word
addr  in  32  byte address from ALU
wdata  in  32  store data (rs2)
rdata  out  32  aligned/extended load result
rdata_valid  out  1  rdata valid this cycle
stall  out  1  hold PC and pipeline
misalign  out  1  one-cycle pulse: misaligned access dropped
dmem_addr  out  DMEM_AW  RAM word address (addr[DMEM_AW+1:2])
dmem_we  out  4  RAM byte write enables
dmem_wdata  out  32  RAM write data, lane-replicated
dmem_rdata  in  32  RAM read data, valid 1 cycle after address
sw_in  in  16  raw switches
btn_in  in  5  raw buttons
led_out  out  16  LED register
seg_out  out  32  7-seg display register

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous and active-low. Reset values: state=IDLE, stall=0, rdata=0, rdata_valid=0, misalign=0, led_out=0, seg_out=0, synchronisers=0.
- FSM states: IDLE and RD_WAIT.
- IDLE + mem_read (aligned): stall=1 (combinational) and latch offset/width/sign, then go to RD_WAIT.
- RD_WAIT: stall=0 and rdata_valid=1. rdata is formed from dmem_rdata using the latched info. Return to IDLE.
- Stores: single cycle, no stall. dmem_we: byte = 1<<addr[1:0]; half = 0011 or 1100; word = 1111. dmem_wdata replicates the byte/half across lanes.
- Alignment: half requires addr[0]=0; word requires addr[1:0]=0. A misaligned access is suppressed (no write enables, no stall), misalign pulses for 1 cycle and rdata=0.
- Load extension: bit 7 or bit 15 is replicated when is_signed=1, else zero-filled. Word loads ignore is_signed.
- MMIO (word-decoded on addr[7:0], upper 16 bits 0xFFFF):
  - 0x00 switches (RO)
  - 0x10 buttons (RO)
  - 0x60 LEDs (RW, low 16 bits)
  - 0x70 seg (RW, 32 bits)
- MMIO reads are combinational: rdata_valid in the same cycle, no stall. Unmapped reads return 0; unmapped writes are ignored. MMIO accesses use word semantics regardless of funct3.
- Switch and button inputs pass through SYNC_STAGES flops before being read.
- Simultaneous mem_read and mem_write is illegal; mem_read takes priority and the write is dropped.
- mem_* together with io_* is impossible by decode; io wins.
- Asserting rst_n mid RD_WAIT returns the FSM to IDLE and drops the pending load.

Optional Feature:
- Macro: MMIO_CYCLE_COUNTER_EN.
- Defined: adds a 32-bit free-running cycle counter, reset 0, wrapping 0xFFFFFFFF to 0, readable at 0xFFFFFC80. A write to it clears it to 0.
- Undefined: 0xFFFFFC80 is unmapped (reads 0).

Decomposition:
- Shared package: width constants (FUNCT3 byte/half/word codes), MMIO offset constants, IO base 16'hFFFF, state enum {IDLE, RD_WAIT}.
- One sub-module: load_align (pure combinational). Inputs: word, offset, width, is_signed. Output: 32-bit extended result. The main block uses it on the RAM path.

Test Plan:
- lw at 0x100, dmem_rdata=0xDEADBEEF at the next cycle -> stall=1 for 1 cycle, then rdata=0xDEADBEEF and rdata_valid=1, state back to IDLE.
- lb addr 0x103 (is_signed=1), RAM word 0x80FF0000 -> rdata=0xFFFFFF80. Same access as lbu -> rdata=0x00000080.
- sh wdata=0x1234 addr 0x202 -> dmem_we=1100, dmem_wdata=0x12341234, no stall.
- sw 0xA5A5 to 0xFFFFFC60, then lw 0xFFFFFC60 -> led_out=0xA5A5, rdata=0x0000A5A5 in the same cycle, no stall. sw_in=0x00F0 held for 2 cycles, then read 0xFFFFFC00 -> 0x000000F0.
- lh addr 0x101 -> misalign pulses 1 cycle, dmem_we=0000, stall=0.
- rst_n low during RD_WAIT -> stall=0 and rdata_valid=0 immediately; IDLE after release.

Source files
------------

// File: rtl/mem_io_unit_pkg.sv
// Shared constants and types for the load/store stage.
// Holds access-width codes, MMIO offsets, the IO base, the FSM state enum,
// the latched load-info payload and the alignment helper.
package mem_io_unit_pkg;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned SW_W  = 16;
  localparam int unsigned BTN_W = 5;

  // funct3[1:0] access width codes
  localparam logic [1:0] WIDTH_BYTE = 2'd0;
  localparam logic [1:0] WIDTH_HALF = 2'd1;
  localparam logic [1:0] WIDTH_WORD = 2'd2;

  // MMIO window and word offsets within it
  localparam logic [15:0] IO_BASE   = 16'hFFFF;
  localparam logic [7:0]  MMIO_SW   = 8'h00;
  localparam logic [7:0]  MMIO_BTN  = 8'h10;
  localparam logic [7:0]  MMIO_LED  = 8'h60;
  localparam logic [7:0]  MMIO_SEG  = 8'h70;
  localparam logic [7:0]  MMIO_CYC  = 8'h80;

  typedef enum logic {
    IDLE    = 1'b0,
    RD_WAIT = 1'b1
  } state_e;

  // Information captured at load issue and consumed when RAM data returns
  typedef struct packed {
    logic [1:0] offset;
    logic [1:0] width;
    logic       is_signed;
  } ld_info_t;

  // Half needs an even address, word (and the reserved code) a 4-byte boundary
  function automatic logic is_aligned(input logic [1:0] width, input logic [1:0] off);
    case (width)
      WIDTH_BYTE: return 1'b1;
      WIDTH_HALF: return ~off[0];
      default:    return (off == 2'b00);
    endcase
  endfunction

endpackage

// File: rtl/mem_io_unit_if.sv
// Core-side load/store bus plus the data RAM port of the load/store stage.
// master: driven by the core/decoder and RAM; slave: the mem_io_unit.
interface mem_io_unit_if #(
  parameter int unsigned DMEM_AW = 14
);
  logic               mem_read;
  logic               mem_write;
  logic               io_read;
  logic               io_write;
  logic               is_signed;
  logic [2:0]         funct3;
  logic [31:0]        addr;
  logic [31:0]        wdata;
  logic [31:0]        rdata;
  logic               rdata_valid;
  logic               stall;
  logic               misalign;
  logic [DMEM_AW-1:0] dmem_addr;
  logic [3:0]         dmem_we;
  logic [31:0]        dmem_wdata;
  logic [31:0]        dmem_rdata;

  modport master (
    output mem_read, mem_write, io_read, io_write, is_signed, funct3, addr, wdata,
    output dmem_rdata,
    input  rdata, rdata_valid, stall, misalign, dmem_addr, dmem_we, dmem_wdata
  );

  modport slave (
    input  mem_read, mem_write, io_read, io_write, is_signed, funct3, addr, wdata,
    input  dmem_rdata,
    output rdata, rdata_valid, stall, misalign, dmem_addr, dmem_we, dmem_wdata
  );
endinterface

// File: rtl/mem_io_unit_load_align.sv
// Load data aligner: selects the addressed byte/half of a RAM word and
// sign- or zero-extends it. Word loads pass through unchanged.
// Ports: word (RAM word), offset (byte offset), width (funct3[1:0]),
//        is_signed, result (32-bit extended load value).
module mem_io_unit_load_align
  import mem_io_unit_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  offset,
  input  logic [1:0]  width,
  input  logic        is_signed,
  output logic [31:0] result
);

  logic [7:0]  byte_v;
  logic [15:0] half_v;

  always_comb begin
    byte_v = 8'(word >> {offset, 3'b000});
    half_v = offset[1] ? word[31:16] : word[15:0];
    result = word;
    case (width)
      WIDTH_BYTE: result = {{24{is_signed & byte_v[7]}}, byte_v};
      WIDTH_HALF: result = {{16{is_signed & half_v[15]}}, half_v};
      default:    result = word;
    endcase
  end

endmodule

// File: rtl/mem_io_unit.sv
// Load/store stage: routes decoder requests to the synchronous data RAM
// (1-cycle read latency, one stall cycle per load) or to MMIO registers
// (combinational reads, single-cycle writes). Aligns/extends loads and
// drops misaligned accesses with a one-cycle misalign pulse.
// Ports: clk, rst_n (async active-low), bus (mem_io_unit_if.slave: decoder
//        requests, load result, stall/misalign, RAM port), sw_in, btn_in
//        (raw, synchronised internally), led_out, seg_out (MMIO registers).
// Build option: MMIO_CYCLE_COUNTER_EN adds a clearable free-running cycle
//        counter at 0xFFFFFC80; without it that address reads 0.
module mem_io_unit
  import mem_io_unit_pkg::*;
#(
  parameter int unsigned DMEM_AW     = 14,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  mem_io_unit_if.slave       bus,
  input  logic [SW_W-1:0]    sw_in,
  input  logic [BTN_W-1:0]   btn_in,
  output logic [15:0]        led_out,
  output logic [31:0]        seg_out
);

  state_e                          state_q, state_d;
  ld_info_t                        ld_q;
  logic                            rd_go;
  logic                            stall_c, rvalid_c, misalign_c;
  logic [31:0]                     rdata_c, io_rdata, ld_word, wdata_rep;
  logic [3:0]                      we_c, we_mask;
  logic [1:0]                      width, off;
  logic                            aligned, io_acc, io_hit, io_wr_en;
  logic [7:0]                      io_sel;
  logic [SYNC_STAGES-1:0][SW_W-1:0]  sw_sync;
  logic [SYNC_STAGES-1:0][BTN_W-1:0] btn_sync;
  logic                            unused_funct3;

  assign unused_funct3 = bus.funct3[2];

  assign width   = bus.funct3[1:0];
  assign off     = bus.addr[1:0];
  assign aligned = is_aligned(width, off);
  assign io_acc  = bus.io_read | bus.io_write;
  assign io_hit  = (bus.addr[31:16] == IO_BASE);
  assign io_sel  = {bus.addr[7:2], 2'b00};
  assign io_wr_en = (state_q == IDLE) & bus.io_write & io_hit;

  // Store lane enables and lane-replicated store data
  always_comb begin
    we_mask   = 4'b1111;
    wdata_rep = bus.wdata;
    case (width)
      WIDTH_BYTE: begin
        we_mask   = 4'(4'b0001 << off);
        wdata_rep = {4{bus.wdata[7:0]}};
      end
      WIDTH_HALF: begin
        we_mask   = off[1] ? 4'b1100 : 4'b0011;
        wdata_rep = {2{bus.wdata[15:0]}};
      end
      default: begin
        we_mask   = 4'b1111;
        wdata_rep = bus.wdata;
      end
    endcase
  end

`ifdef MMIO_CYCLE_COUNTER_EN
  logic [31:0] cyc_cnt;

  // Free-running cycle counter; an MMIO write clears it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                               cyc_cnt <= '0;
    else if (io_wr_en && io_sel == MMIO_CYC)  cyc_cnt <= '0;
    else                                      cyc_cnt <= cyc_cnt + 32'd1;
  end
`endif

  // MMIO read mux (word semantics, unmapped reads return 0)
  always_comb begin
    io_rdata = '0;
    if (io_hit) begin
      case (io_sel)
        MMIO_SW:  io_rdata = 32'(sw_sync[SYNC_STAGES-1]);
        MMIO_BTN: io_rdata = 32'(btn_sync[SYNC_STAGES-1]);
        MMIO_LED: io_rdata = 32'(led_out);
        MMIO_SEG: io_rdata = seg_out;
`ifdef MMIO_CYCLE_COUNTER_EN
        MMIO_CYC: io_rdata = cyc_cnt;
`endif
        default:  io_rdata = '0;
      endcase
    end
  end

  mem_io_unit_load_align u_load_align (
    .word      (bus.dmem_rdata),
    .offset    (ld_q.offset),
    .width     (ld_q.width),
    .is_signed (ld_q.is_signed),
    .result    (ld_word)
  );

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // FSM next state and access control; io beats mem, mem_read beats mem_write
  always_comb begin
    state_d    = state_q;
    stall_c    = 1'b0;
    rdata_c    = '0;
    rvalid_c   = 1'b0;
    misalign_c = 1'b0;
    we_c       = '0;
    rd_go      = 1'b0;
    case (state_q)
      IDLE: begin
        if (io_acc) begin
          if (bus.io_read) begin
            rdata_c  = io_rdata;
            rvalid_c = 1'b1;
          end
        end else if (bus.mem_read) begin
          if (aligned) begin
            stall_c = 1'b1;
            rd_go   = 1'b1;
            state_d = RD_WAIT;
          end else begin
            misalign_c = 1'b1;
          end
        end else if (bus.mem_write) begin
          if (aligned) we_c = we_mask;
          else         misalign_c = 1'b1;
        end
      end
      RD_WAIT: begin
        rdata_c  = ld_word;
        rvalid_c = 1'b1;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Load info captured at issue for use when the RAM word returns
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     ld_q <= '0;
    else if (rd_go) ld_q <= '{offset: off, width: width, is_signed: bus.is_signed};
  end

  // MMIO writable registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      led_out <= '0;
      seg_out <= '0;
    end else if (io_wr_en) begin
      if (io_sel == MMIO_LED) led_out <= bus.wdata[15:0];
      if (io_sel == MMIO_SEG) seg_out <= bus.wdata;
    end
  end

  // Input synchronisers for switches and buttons
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sw_sync  <= '0;
      btn_sync <= '0;
    end else begin
      sw_sync  <= {sw_sync[SYNC_STAGES-2:0], sw_in};
      btn_sync <= {btn_sync[SYNC_STAGES-2:0], btn_in};
    end
  end

  assign bus.rdata       = rdata_c;
  assign bus.rdata_valid = rvalid_c;
  assign bus.stall       = stall_c;
  assign bus.misalign    = misalign_c;
  assign bus.dmem_addr   = bus.addr[DMEM_AW+1:2];
  assign bus.dmem_we     = we_c;
  assign bus.dmem_wdata  = wdata_rep;

endmodule
